// File: rtl/uart_receiver.sv
// ----------------------------------------------------------------------------
// uart_receiver
//   8N1 UART receiver. Synchronizes the asynchronous RXD line, detects the
//   start edge, samples every bit mid-cell, and presents each received byte
//   (LSB first on the wire) through a single-entry valid/ready holding
//   register. Framing errors and overruns are reported with sticky flags.
//
// Parameters
//   clk_freq_hz  i_clk frequency in Hz
//   baud_rate    line rate in bit/s
//   DIV = clk_freq_hz / baud_rate clocks per bit (must be >= 4), HALF = DIV/2
//
// Ports
//   i_clk        system clock
//   i_rst        asynchronous, active-high reset
//   i_uart_rx    serial line, idle high, asynchronous to i_clk
//   o_data       received byte, stable while o_valid = 1
//   o_valid      o_data holds an unread byte
//   i_ready      consumer takes o_data on an edge where o_valid & i_ready
//   i_clr_err    one-cycle pulse clearing both sticky flags
//   o_frame_err  sticky: a stop bit was sampled low
//   o_overrun    sticky: a completed byte was dropped (holding register full)
//   o_busy       receiver is inside a frame (state != IDLE)
// ----------------------------------------------------------------------------
module uart_receiver #(
  parameter int clk_freq_hz = 100_000_000,
  parameter int baud_rate   = 1_000_000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_uart_rx,
  output logic [7:0] o_data,
  output logic       o_valid,
  input  logic       i_ready,
  input  logic       i_clr_err,
  output logic       o_frame_err,
  output logic       o_overrun,
  output logic       o_busy
);

  localparam int DIV   = clk_freq_hz / baud_rate;
  localparam int HALF  = DIV / 2;
  localparam int CNT_W = $clog2(DIV);

  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  // Line synchronizer and edge-detect history
  logic             r_sync1;
  logic             r_rx_s;
  logic             r_rx_prev;

  // Frame FSM and bit timer
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_shift;

  // Holding register and sticky flags
  logic [7:0]       r_data;
  logic             r_valid;
  logic             r_frame_err;
  logic             r_overrun;

  // Next-state / event signals from the combinational process
  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [2:0]       w_bit_nxt;
  logic [7:0]       w_shift_nxt;
  logic             w_push;
  logic             w_ferr_evt;
  logic             w_ovr_evt;
  logic             w_load;

  // Synchronizer resets to the idle level so that reset release with an idle
  // line never looks like a start edge.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync1   <= 1'b1;
      r_rx_s    <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments make every flop sample the pre-edge
      // value of its source, which is what turns this chain into a real
      // two-stage synchronizer plus one-cycle delay rather than a wire.
      r_sync1   <= i_uart_rx;
      r_rx_s    <= r_sync1;
      r_rx_prev <= r_rx_s;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first; any path that
    // left one unassigned would infer a latch.
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_bit_nxt   = r_bit_idx;
    w_shift_nxt = r_shift;
    w_push      = 1'b0;
    w_ferr_evt  = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        // Only a 1->0 transition starts a frame; a line stuck low does not.
        if (r_rx_prev && !r_rx_s) begin
          w_state_nxt = S_START;
          w_cnt_nxt   = CNT_HALF;
        end
      end

      S_START: begin
        if (r_cnt == '0) begin
          if (!r_rx_s) begin
            w_state_nxt = S_DATA;
            w_cnt_nxt   = CNT_FULL;
            w_bit_nxt   = 3'd0;
          end else begin
            // Start bit gone high by mid-cell: treat as a glitch, silently.
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_cnt_nxt = r_cnt - CNT_ONE;
        end
      end

      S_DATA: begin
        if (r_cnt == '0) begin
          // LSB arrives first, so shifting right leaves bit 0 in place after 8 samples.
          w_shift_nxt = {r_rx_s, r_shift[7:1]};
          w_cnt_nxt   = CNT_FULL;
          if (r_bit_idx == 3'd7) begin
            w_state_nxt = S_STOP;
          end else begin
            w_bit_nxt = r_bit_idx + 3'd1;
          end
        end else begin
          w_cnt_nxt = r_cnt - CNT_ONE;
        end
      end

      S_STOP: begin
        if (r_cnt == '0) begin
          // Back to IDLE at the mid-stop sample so a short stop bit still
          // lets the next start edge be caught.
          w_state_nxt = S_IDLE;
          if (r_rx_s) begin
            w_push = 1'b1;
          end else begin
            w_ferr_evt = 1'b1;
          end
        end else begin
          w_cnt_nxt = r_cnt - CNT_ONE;
        end
      end

      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_bit_idx <= 3'd0;
      r_shift   <= 8'h00;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_bit_idx <= w_bit_nxt;
      r_shift   <= w_shift_nxt;
    end
  end

  // A push is accepted when the holding register is empty or is being
  // drained in the same cycle; otherwise the new byte is the one dropped.
  assign w_load    = w_push && (!r_valid || i_ready);
  assign w_ovr_evt = w_push && r_valid && !i_ready;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_data      <= 8'h00;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      if (w_load) begin
        r_data  <= r_shift;
        r_valid <= 1'b1;
      end else if (r_valid && i_ready) begin
        r_valid <= 1'b0;
      end
      // A new error event overrides a coincident clear.
      r_frame_err <= w_ferr_evt | (r_frame_err & ~i_clr_err);
      r_overrun   <= w_ovr_evt  | (r_overrun   & ~i_clr_err);
    end
  end

  assign o_data      = r_data;
  assign o_valid     = r_valid;
  assign o_frame_err = r_frame_err;
  assign o_overrun   = r_overrun;
  assign o_busy      = (r_state != S_IDLE);

endmodule
